// File: rtl/bt_uart_cmd_decoder.sv
// 8N1 UART receiver plus command decoder for the Bluetooth remote.
// Owns the song index, pause flag and volume level, and emits one-cycle event pulses.
module bt_uart_cmd_decoder #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned SONG_NUM = 4,
  parameter logic [7:0]  VOL_STEP = 8'h10,
  parameter int unsigned VOL_RST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        i_finish_song,
  output logic [15:0] o_vol,
  output logic [3:0]  vol_level,
  output logic [2:0]  o_song_select,
  output logic        o_pause,
  output logic        o_next,
  output logic        o_pre,
  output logic        o_vol_plus,
  output logic        o_vol_dec,
  output logic        o_frame_err
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned TimerW     = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
  localparam logic [TimerW-1:0] BitLast  = TimerW'(ClksPerBit - 1);
  localparam logic [TimerW-1:0] HalfLast = TimerW'(ClksPerBit / 2 - 1);
  localparam logic [2:0] SongLast = 3'(SONG_NUM - 1);
  localparam logic [3:0] VolRst   = 4'(VOL_RST);
  localparam logic [3:0] VolMax   = 4'd8;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid, byte_valid_d;
  logic              frame_err_d;
  logic              rx_meta, rx_sync, rx_prev;

  logic [2:0] sel_d, sel_inc, sel_dec;
  logic [3:0] vol_d;
  logic       pause_d, next_d, pre_d, plus_d, dec_d;
  logic       host_nav;
  logic [7:0] att;

  // UART receive FSM
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (rx_prev && !rx_sync) state_d = StStart;
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_sync ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d   = '0;
          shift_d   = {rx_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          state_d = StIdle;
          if (rx_sync) byte_valid_d = 1'b1;
          else         frame_err_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign sel_inc  = (o_song_select == SongLast) ? 3'd0 : o_song_select + 3'd1;
  assign sel_dec  = (o_song_select == 3'd0) ? SongLast : o_song_select - 3'd1;
  assign host_nav = byte_valid && (shift_q == 8'h02 || shift_q == 8'h03);

  // Command decode; a host next/previous swallows a coincident finish strobe.
  always_comb begin
    sel_d   = o_song_select;
    pause_d = o_pause;
    vol_d   = vol_level;
    next_d  = 1'b0;
    pre_d   = 1'b0;
    plus_d  = 1'b0;
    dec_d   = 1'b0;
    if (i_finish_song && !host_nav) begin
      sel_d   = sel_inc;
      pause_d = 1'b0;
    end
    if (byte_valid) begin
      case (shift_q)
        8'h01: pause_d = ~pause_d;
        8'h02: begin
          sel_d   = sel_inc;
          pause_d = 1'b0;
          next_d  = 1'b1;
        end
        8'h03: begin
          sel_d   = sel_dec;
          pause_d = 1'b0;
          pre_d   = 1'b1;
        end
        8'h04: begin
          if (vol_level != 4'd0) begin
            vol_d  = vol_level - 4'd1;
            plus_d = 1'b1;
          end
        end
        8'h05: begin
          if (vol_level < VolMax) begin
            vol_d = vol_level + 4'd1;
            dec_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_prev       <= 1'b1;
      state_q       <= StIdle;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_valid    <= 1'b0;
      o_frame_err   <= 1'b0;
      o_song_select <= 3'd0;
      o_pause       <= 1'b0;
      vol_level     <= VolRst;
      o_next        <= 1'b0;
      o_pre         <= 1'b0;
      o_vol_plus    <= 1'b0;
      o_vol_dec     <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_prev       <= rx_sync;
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid    <= byte_valid_d;
      o_frame_err   <= frame_err_d;
      o_song_select <= sel_d;
      o_pause       <= pause_d;
      vol_level     <= vol_d;
      o_next        <= next_d;
      o_pre         <= pre_d;
      o_vol_plus    <= plus_d;
      o_vol_dec     <= dec_d;
    end
  end

  assign att   = {4'b0000, vol_level} * VOL_STEP;
  assign o_vol = {att, att};

endmodule

// File: tb/tb_bt_uart_cmd_decoder.sv
// Bench for bt_uart_cmd_decoder: directed scenarios then random command bytes,
// checked against a simple playback-state model.
module tb_bt_uart_cmd_decoder;

  localparam int Cpb     = 10;
  localparam int SongNum = 4;

  logic        clk, rst, rx, i_finish_song;
  logic [15:0] o_vol;
  logic [3:0]  vol_level;
  logic [2:0]  o_song_select;
  logic        o_pause, o_next, o_pre, o_vol_plus, o_vol_dec, o_frame_err;

  int checks = 0;
  int errors = 0;
  int cnt_next = 0, cnt_pre = 0, cnt_plus = 0, cnt_dec = 0, cnt_ferr = 0;
  int m_sel, m_pause, m_vol;
  int e_next = 0, e_pre = 0, e_plus = 0, e_dec = 0, e_ferr = 0;

  bt_uart_cmd_decoder #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000),
    .SONG_NUM(SongNum),
    .VOL_STEP(8'h10),
    .VOL_RST (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .i_finish_song(i_finish_song),
    .o_vol        (o_vol),
    .vol_level    (vol_level),
    .o_song_select(o_song_select),
    .o_pause      (o_pause),
    .o_next       (o_next),
    .o_pre        (o_pre),
    .o_vol_plus   (o_vol_plus),
    .o_vol_dec    (o_vol_dec),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse widths are checked by counting high cycles per event.
  always @(negedge clk) begin
    cnt_next <= cnt_next + int'(o_next);
    cnt_pre  <= cnt_pre + int'(o_pre);
    cnt_plus <= cnt_plus + int'(o_vol_plus);
    cnt_dec  <= cnt_dec + int'(o_vol_dec);
    cnt_ferr <= cnt_ferr + int'(o_frame_err);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_sel   = 0;
    m_pause = 0;
    m_vol   = 2;
  endtask

  task automatic model_cmd(input logic [7:0] b, input bit fin);
    if (fin && b != 8'h02 && b != 8'h03) begin
      m_sel   = (m_sel + 1) % SongNum;
      m_pause = 0;
    end
    case (b)
      8'h01: m_pause = m_pause ? 0 : 1;
      8'h02: begin m_sel = (m_sel + 1) % SongNum; m_pause = 0; e_next++; end
      8'h03: begin m_sel = (m_sel + SongNum - 1) % SongNum; m_pause = 0; e_pre++; end
      8'h04: if (m_vol > 0) begin m_vol--; e_plus++; end
      8'h05: if (m_vol < 8) begin m_vol++; e_dec++; end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int att;
    att = (m_vol * 16) & 255;
    check({tag, "_sel"},   32'(o_song_select), 32'(m_sel));
    check({tag, "_pause"}, 32'(o_pause),       32'(m_pause));
    check({tag, "_vlvl"},  32'(vol_level),     32'(m_vol));
    check({tag, "_ovol"},  32'(o_vol),         32'(att * 257));
    check({tag, "_nnext"}, 32'(cnt_next),      32'(e_next));
    check({tag, "_npre"},  32'(cnt_pre),       32'(e_pre));
    check({tag, "_nplus"}, 32'(cnt_plus),      32'(e_plus));
    check({tag, "_ndec"},  32'(cnt_dec),       32'(e_dec));
    check({tag, "_nferr"}, 32'(cnt_ferr),      32'(e_ferr));
  endtask

  // Sends one frame; with_fin raises the finish strobe on the decode cycle.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit with_fin);
    bit fired;
    fired = 1'b0;
    rx = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = stop_bit;
    for (int c = 0; c < Cpb + 6; c++) begin
      if (c == Cpb) rx = 1'b1;
      i_finish_song = 1'b0;
      if (with_fin && !fired && dut.byte_valid) begin
        i_finish_song = 1'b1;
        fired = 1'b1;
      end
      @(negedge clk);
    end
    i_finish_song = 1'b0;
    repeat (4) @(negedge clk);
    if (with_fin) check("fin_sync_seen", 32'(fired), 32'd1);
  endtask

  task automatic finish_alone();
    i_finish_song = 1'b1;
    @(negedge clk);
    i_finish_song = 1'b0;
    repeat (3) @(negedge clk);
    model_cmd(8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    rst = 1'b1;
    rx = 1'b1;
    i_finish_song = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("reset");

    // next x3 then wrap
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h02, 1'b1, 1'b0);
      model_cmd(8'h02, 1'b0);
      check_all("next");
    end
    check("next_wrap", 32'(o_song_select), 32'd0);

    // previous wrap, pause toggles, next clears pause
    send_byte(8'h03, 1'b1, 1'b0); model_cmd(8'h03, 1'b0); check_all("pre");
    check("pre_wrap", 32'(o_song_select), 32'd3);
    send_byte(8'h01, 1'b1, 1'b0); model_cmd(8'h01, 1'b0); check_all("pause1");
    send_byte(8'h01, 1'b1, 1'b0); model_cmd(8'h01, 1'b0); check_all("pause0");
    send_byte(8'h01, 1'b1, 1'b0); model_cmd(8'h01, 1'b0); check_all("pause1b");
    send_byte(8'h02, 1'b1, 1'b0); model_cmd(8'h02, 1'b0); check_all("next_unpause");

    // volume saturation at both ends
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h04, 1'b1, 1'b0); model_cmd(8'h04, 1'b0); check_all("volp");
    end
    check("volp_floor", 32'(o_vol), 32'h0000);
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h05, 1'b1, 1'b0); model_cmd(8'h05, 1'b0); check_all("vold");
    end
    check("vold_ceil", 32'(o_vol), 32'h8080);

    // framing error, glitch, then clean frame
    send_byte(8'h02, 1'b0, 1'b0);
    e_ferr++;
    check_all("ferr");
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check_all("glitch");
    send_byte(8'h02, 1'b1, 1'b0); model_cmd(8'h02, 1'b0); check_all("post_err");

    // finish strobe coincident with next, then alone from the last song
    send_byte(8'h02, 1'b1, 1'b1); model_cmd(8'h02, 1'b1); check_all("fin_next");
    for (int i = 0; i < SongNum && m_sel != SongNum - 1; i++) begin
      send_byte(8'h02, 1'b1, 1'b0); model_cmd(8'h02, 1'b0);
    end
    check_all("to_last");
    finish_alone();
    check_all("fin_alone");
    check("fin_wrap", 32'(o_song_select), 32'd0);

    // reset in the middle of a frame
    send_byte(8'h01, 1'b1, 1'b0); model_cmd(8'h01, 1'b0);
    rx = 1'b0;
    repeat (2 * Cpb) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    model_reset();
    check_all("midrst");
    send_byte(8'h05, 1'b1, 1'b0); model_cmd(8'h05, 1'b0); check_all("after_rst");
    check("after_rst_vol", 32'(o_vol), 32'h3030);

    // random command bytes, including ignored values
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 7));
      send_byte(b, 1'b1, 1'b0);
      model_cmd(b, 1'b0);
      check_all($sformatf("rand%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        finish_alone();
        check_all($sformatf("rfin%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
